// File: rtl/reg_seq_ctrl.sv
// Sequencer that turns one register-to-register ALU instruction into
// read rs1 / read rs2 / execute / write-back on a single-port register file.
// Build option: define RSEQ_R0_PROTECT_EN to make register 0 read-only (no write-back when rd==0).
//
// state  | meaning
// IDLE   | waiting for start; fields captured on start
// RD1    | rf_address=rs1, read strobe, opA latched at exit
// RD2    | rf_address=rs2, read strobe, opB latched at exit
// EXEC   | ALU result and flags registered at exit
// WB     | rf_address=rd, write strobe, rf_wbus=result
// DONE   | one-cycle done pulse, then IDLE
module reg_seq_ctrl #(
  parameter int DW = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [AW-1:0] rd,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          flag_zero,
  output logic          flag_carry,
  output logic [AW-1:0] rf_address,
  output logic          rf_read,
  output logic          rf_write,
  output logic [DW-1:0] rf_wbus,
  input  logic [DW-1:0] rf_rbus
);

  typedef enum logic [2:0] {
    S_IDLE, S_RD1, S_RD2, S_EXEC, S_WB, S_DONE
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_MOV = 3'd5;
  localparam logic [2:0] OP_NOT = 3'd6;
  localparam logic [2:0] OP_CMP = 3'd7;

  state_t        state_q, state_d;
  logic [2:0]    op_q;
  logic [AW-1:0] rd_q, rs1_q, rs2_q;
  logic [DW-1:0] opa_q, opb_q;
  logic [DW-1:0] result_q;
  logic          zero_q, carry_q;
  logic [DW-1:0] alu_res;
  logic          alu_c;
  logic          skip_wb;

`ifdef RSEQ_R0_PROTECT_EN
  assign skip_wb = (op_q == OP_CMP) || (rd_q == '0);
`else
  assign skip_wb = (op_q == OP_CMP);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RD1;
      S_RD1:   state_d = S_RD2;
      S_RD2:   state_d = S_EXEC;
      S_EXEC:  state_d = skip_wb ? S_DONE : S_WB;
      S_WB:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // rf_* are pure decodes of state so an async reset removes the write strobe at once
  always_comb begin
    rf_address = '0;
    rf_read    = 1'b0;
    rf_write   = 1'b0;
    rf_wbus    = '0;
    case (state_q)
      S_RD1: begin rf_address = rs1_q; rf_read = 1'b1; end
      S_RD2: begin rf_address = rs2_q; rf_read = 1'b1; end
      S_WB: begin
        rf_address = rd_q;
        rf_write   = 1'b1;
        rf_wbus    = result_q;
      end
      default: ;
    endcase
    busy = (state_q != S_IDLE);
    done = (state_q == S_DONE);
  end

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OP_ADD:         {alu_c, alu_res} = {1'b0, opa_q} + {1'b0, opb_q};
      OP_SUB, OP_CMP: begin alu_res = opa_q - opb_q; alu_c = (opa_q < opb_q); end
      OP_AND:         alu_res = opa_q & opb_q;
      OP_OR:          alu_res = opa_q | opb_q;
      OP_XOR:         alu_res = opa_q ^ opb_q;
      OP_MOV:         alu_res = opa_q;
      OP_NOT:         alu_res = ~opa_q;
      default:        alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q     <= '0;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      carry_q  <= 1'b0;
    end else begin
      if (state_q == S_IDLE && start) begin
        op_q  <= op;
        rd_q  <= rd;
        rs1_q <= rs1;
        rs2_q <= rs2;
      end
      if (state_q == S_RD1) opa_q <= rf_rbus;
      if (state_q == S_RD2) opb_q <= rf_rbus;
      if (state_q == S_EXEC) begin
        result_q <= alu_res;
        zero_q   <= (alu_res == '0);
        carry_q  <= alu_c;
      end
    end
  end

  assign result     = result_q;
  assign flag_zero  = zero_q;
  assign flag_carry = carry_q;

endmodule
